// File: rtl/base_ram_ctrl_if.sv
// Data-memory request bus between the MEM stage (master) and the base SRAM
// controller (slave).
//   mem_ce_i    request valid            mem_rdata_o  read data, valid with done
//   mem_we_i    1=write, 0=read          mem_done_o   one-cycle completion pulse
//   mem_addr_i  byte address             stall_o      request pending, not done
//   mem_sel_i   byte lanes (sel[3]=byte offset 0)
//   mem_data_i  write data, pipeline lane order
interface base_ram_ctrl_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        stall_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_rdata_o, mem_done_o, stall_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_rdata_o, mem_done_o, stall_o
  );
endinterface

// File: rtl/base_ram_ctrl.sv
// Base SRAM controller: responder end of the pipeline data-memory bus. Runs accepted requests
// on the external asynchronous base SRAM with WAIT_CYCLES-long read access / write pulse and
// holds the pipeline through stall until the access completes. Requests outside the 4 MiB window
// at BASE_ADDR complete without touching the SRAM.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   bus (slave)         request bus from the MEM stage (see base_ram_ctrl_if)
//   base_ram_addr_o     SRAM word address (byte address bits 21:2)
//   base_ram_be_n_o     SRAM byte enables, active-low, be_n[k] -> data[8k+7:8k]
//   base_ram_ce_n_o     SRAM chip enable, active-low
//   base_ram_oe_n_o     SRAM output enable, active-low
//   base_ram_we_n_o     SRAM write enable, active-low
//   base_ram_data_o     SRAM write data, SRAM lane order
//   base_ram_data_oe    drive enable for the SRAM data bus (tristate resolved at top level)
//   base_ram_data_i     SRAM read data, SRAM lane order
//
// Configuration macro BASE_RAM_BYTESWAP_EN: when defined, pipeline byte offset k maps to SRAM
// lane k (byte reversal) for write data, byte enables and read data; otherwise lanes map
// straight through.
module base_ram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000
) (
  input  logic              clk,
  input  logic              rst,
  base_ram_ctrl_if.slave    bus,
  output logic [19:0]       base_ram_addr_o,
  output logic [3:0]        base_ram_be_n_o,
  output logic              base_ram_ce_n_o,
  output logic              base_ram_oe_n_o,
  output logic              base_ram_we_n_o,
  output logic [31:0]       base_ram_data_o,
  output logic              base_ram_data_oe,
  input  logic [31:0]       base_ram_data_i
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD       = 3'd1;
  localparam logic [2:0] WR_SETUP = 3'd2;
  localparam logic [2:0] WR_PULSE = 3'd3;
  localparam logic [2:0] WR_HOLD  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] WIN_SIZE = 32'h0040_0000;

`ifdef BASE_RAM_BYTESWAP_EN
  function automatic logic [31:0] lane_data(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  function automatic logic [3:0] lane_sel(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction
`else
  function automatic logic [31:0] lane_data(input logic [31:0] x);
    return x;
  endfunction
  function automatic logic [3:0] lane_sel(input logic [3:0] s);
    return s;
  endfunction
`endif

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] addr_off;
  logic        in_range;

  // Window check on the address being captured at the accept edge; subtraction form avoids
  // overflow of BASE_ADDR + size for bases near the top of the address space.
  assign addr_off = bus.mem_addr_i - BASE_ADDR;
  assign in_range = (bus.mem_addr_i >= BASE_ADDR) && (addr_off < WIN_SIZE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_ce_i) begin
          addr_d  = bus.mem_addr_i[21:2];
          sel_d   = bus.mem_sel_i;
          data_d  = bus.mem_data_i;
          rdata_d = '0;
          cnt_d   = CNT_INIT;
          if (!in_range) begin
            state_d = DONE;
          end else if (!bus.mem_we_i) begin
            state_d = RD;
          end else if (bus.mem_sel_i != 4'b0000) begin
            state_d = WR_SETUP;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d = lane_data(base_ram_data_i);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        cnt_d   = CNT_INIT;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  logic in_wr;
  assign in_wr = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);

  // SRAM strobes decode straight from state so a reset releases the SRAM on the same edge.
  always_comb begin
    base_ram_ce_n_o  = !((state_q == RD) || in_wr);
    base_ram_oe_n_o  = !(state_q == RD);
    base_ram_we_n_o  = !(state_q == WR_PULSE);
    base_ram_data_oe = in_wr;
    base_ram_be_n_o  = 4'b1111;
    if (state_q == RD) begin
      base_ram_be_n_o = 4'b0000;
    end else if (in_wr) begin
      base_ram_be_n_o = ~lane_sel(sel_q);
    end
    base_ram_addr_o = addr_q;
    base_ram_data_o = lane_data(data_q);
  end

  assign bus.mem_rdata_o = rdata_q;
  assign bus.mem_done_o  = (state_q == DONE);
  assign bus.stall_o     = bus.mem_ce_i && (state_q != DONE);

endmodule

// File: tb/tb_base_ram_ctrl.sv
module tb_base_ram_ctrl;

  localparam int W = 2;
`ifdef BASE_RAM_BYTESWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  base_ram_ctrl_if bus ();

  base_ram_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (32'h80000000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .base_ram_addr_o (sram_addr),
    .base_ram_be_n_o (sram_be_n),
    .base_ram_ce_n_o (sram_ce_n),
    .base_ram_oe_n_o (sram_oe_n),
    .base_ram_we_n_o (sram_we_n),
    .base_ram_data_o (sram_wdata),
    .base_ram_data_oe(sram_data_oe),
    .base_ram_data_i (sram_rdata)
  );

  always #5 clk = ~clk;

  // Small SRAM model; the word addresses used here are distinct in their low nibble.
  logic [31:0] mem [16];
  always_comb begin
    sram_rdata = 32'h0;
    if (!sram_ce_n && !sram_oe_n) sram_rdata = mem[sram_addr[3:0]];
  end
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      for (int k = 0; k < 4; k++)
        if (!sram_be_n[k]) mem[sram_addr[3:0]][8*k +: 8] <= sram_wdata[8*k +: 8];
    end
  end

  // Bus monitor
  int          ce_cyc, oe_cyc, we_cyc;
  logic [19:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_data;
  bit          inv_bad = 1'b0;
  always @(negedge clk) begin
    if (!sram_ce_n) begin
      ce_cyc++;
      cap_addr = sram_addr;
    end
    if (!sram_oe_n) oe_cyc++;
    if (!sram_we_n) begin
      we_cyc++;
      cap_be   = sram_be_n;
      cap_data = sram_wdata;
    end
    if (!sram_we_n && !sram_oe_n) inv_bad = 1'b1;
    if (sram_data_oe && (sram_ce_n || !sram_oe_n)) inv_bad = 1'b1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_ce;
    int          exp_oe;
    int          exp_we;
    logic [19:0] exp_addr;
    logic [3:0]  exp_be_n;
    logic [31:0] exp_data_o;
  } vec_t;

  vec_t vecs [12];

  task automatic clr_mon();
    ce_cyc = 0; oe_cyc = 0; we_cyc = 0;
  endtask

  // Called #1 after a posedge with the controller in IDLE.
  task automatic run_vec(input vec_t v);
    int  n;
    bit  stall_bad;
    clr_mon();
    stall_bad = 1'b0;
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = v.we;
    bus.mem_addr_i = v.addr;
    bus.mem_sel_i  = v.sel;
    bus.mem_data_i = v.wdata;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.mem_done_o) break;
      if (!bus.stall_o) stall_bad = 1'b1;
    end
    chk({v.name, " latency"}, n, v.exp_lat);
    chk({v.name, " stall_at_done"}, {31'b0, bus.stall_o}, 32'd0);
    chk({v.name, " stall_before_done"}, {31'b0, stall_bad}, 32'd0);
    if (!v.we) chk({v.name, " rdata"}, bus.mem_rdata_o, v.exp_rdata);
    chk({v.name, " ce_cycles"}, ce_cyc, v.exp_ce);
    chk({v.name, " oe_cycles"}, oe_cyc, v.exp_oe);
    chk({v.name, " we_cycles"}, we_cyc, v.exp_we);
    if (v.exp_ce != 0) chk({v.name, " sram_addr"}, {12'b0, cap_addr}, {12'b0, v.exp_addr});
    if (v.exp_we != 0) begin
      chk({v.name, " be_n"}, {28'b0, cap_be}, {28'b0, v.exp_be_n});
      chk({v.name, " data_o"}, cap_data, v.exp_data_o);
    end
    bus.mem_ce_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int lat, input int ce,
                              input int oe, input int wc, input logic [19:0] a,
                              input logic [3:0] be, input logic [31:0] dout);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_lat = lat; v.exp_ce = ce; v.exp_oe = oe; v.exp_we = wc;
    v.exp_addr = a; v.exp_be_n = be; v.exp_data_o = dout;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_done;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h44332211;

    // Reads: W cycles of oe; writes: setup + W pulse + hold on ce.
    vecs[0]  = mk("lw_base4", 0, 32'h80000004, 4'hF, 0, SWAP ? 32'h11223344 : 32'h44332211,
                  1+W, W, W, 0, 20'h1, 4'h0, 0);
    vecs[1]  = mk("sb_off1", 1, 32'h80000001, 4'b0100, 32'hAAAAAAAA, 0,
                  3+W, W+2, 0, W, 20'h0, SWAP ? 4'b1101 : 4'b1011, 32'hAAAAAAAA);
    vecs[2]  = mk("lw_base0", 0, 32'h80000000, 4'hF, 0, 32'h00AA0000,
                  1+W, W, W, 0, 20'h0, 4'h0, 0);
    vecs[3]  = mk("lw_oor_low", 0, 32'h00001000, 4'hF, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk("sw_top", 1, 32'h803FFFFC, 4'hF, 32'h12345678, 0,
                  3+W, W+2, 0, W, 20'hFFFFF, 4'h0, SWAP ? 32'h78563412 : 32'h12345678);
    vecs[5]  = mk("lw_top", 0, 32'h803FFFFC, 4'hF, 0, 32'h12345678,
                  1+W, W, W, 0, 20'hFFFFF, 4'h0, 0);
    vecs[6]  = mk("sw_sel0", 1, 32'h80000010, 4'h0, 32'hCAFEF00D, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk("lw_oor_end", 0, 32'h80400000, 4'hF, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk("lw_oor_below", 0, 32'h7FFFFFFC, 4'hF, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk("sh_lo", 1, 32'h80000008, 4'b0011, 32'h0000BEEF, 0,
                  3+W, W+2, 0, W, 20'h2, SWAP ? 4'b0011 : 4'b1100,
                  SWAP ? 32'hEFBE0000 : 32'h0000BEEF);
    vecs[10] = mk("lw_sh", 0, 32'h80000008, 4'hF, 0, 32'h0000BEEF,
                  1+W, W, W, 0, 20'h2, 4'h0, 0);
    vecs[11] = mk("sw_oor", 1, 32'h90000000, 4'hF, 32'h11111111, 0, 1, 0, 0, 0, 0, 0, 0);

    bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
    bus.mem_sel_i = '0;  bus.mem_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("rst oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("rst we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst be_n", {28'b0, sram_be_n}, 32'hF);
    chk("rst addr", {12'b0, sram_addr}, 32'd0);
    chk("rst data_o", sram_wdata, 32'd0);
    chk("rst data_oe", {31'b0, sram_data_oe}, 32'd0);
    chk("rst rdata", bus.mem_rdata_o, 32'd0);
    chk("rst done", {31'b0, bus.mem_done_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset during the second write-pulse cycle aborts the access immediately.
    clr_mon();
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h80000020;
    bus.mem_sel_i = 4'hF; bus.mem_data_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("wr setup we_n", {31'b0, sram_we_n}, 32'd1);
    chk("wr setup data_oe", {31'b0, sram_data_oe}, 32'd1);
    @(posedge clk); #1;
    chk("wr pulse1 we_n", {31'b0, sram_we_n}, 32'd0);
    @(posedge clk); #1;
    chk("wr pulse2 we_n", {31'b0, sram_we_n}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort we_n", {31'b0, sram_we_n}, 32'd1);
    chk("abort ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("abort data_oe", {31'b0, sram_data_oe}, 32'd0);
    chk("abort done", {31'b0, bus.mem_done_o}, 32'd0);
    rst = 1'b0;
    bus.mem_ce_i = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.mem_done_o) saw_done = 1'b1;
    end
    chk("abort no done", {31'b0, saw_done}, 32'd0);
    run_vec(vecs[3]);

    // Back-to-back: LW completes, requester switches to a sel=0 SW held by stall.
    clr_mon();
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h80000004;
    bus.mem_sel_i = 4'hF;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.mem_done_o) break;
    end
    chk("b2b lw latency", n, 1 + W);
    chk("b2b lw rdata", bus.mem_rdata_o, SWAP ? 32'h11223344 : 32'h44332211);
    bus.mem_we_i = 1'b1; bus.mem_sel_i = 4'h0; bus.mem_data_i = 32'h55555555;
    @(posedge clk); #1;
    chk("b2b idle done", {31'b0, bus.mem_done_o}, 32'd0);
    chk("b2b idle stall", {31'b0, bus.stall_o}, 32'd1);
    @(posedge clk); #1;
    chk("b2b sw done", {31'b0, bus.mem_done_o}, 32'd1);
    chk("b2b sw we_cycles", we_cyc, 0);
    bus.mem_ce_i = 1'b0;
    @(posedge clk); #1;

    chk("strobe invariants", {31'b0, inv_bad}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
